// File: rtl/bus_arbiter_rr.sv
// Multi-bus packet arbiter/router: per bus, pick one pending driver FIFO,
// pop its head packet and route it by destination ID (unicast or broadcast).
// Unroutable packets are dropped and counted per bus with saturation.
module bus_arbiter_rr #(
    parameter int unsigned bits      = 1,
    parameter int unsigned drvrs     = 4,
    parameter int unsigned pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF,
    parameter int unsigned MODE      = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [bits*drvrs-1:0]           pndng,
    input  logic [bits*drvrs*pckg_sz-1:0]   D_pop,
    output logic [bits*drvrs-1:0]           pop,
    output logic [bits*drvrs-1:0]           push,
    output logic [bits*pckg_sz-1:0]         D_push,
    output logic [bits*16-1:0]              drop_cnt
);

    localparam int unsigned NDRV = bits * drvrs;
    localparam int unsigned CW   = 16;
    localparam int unsigned IDW  = 8;

    localparam logic [1:0] ST_ARB  = 2'd0;
    localparam logic [1:0] ST_POP  = 2'd1;
    localparam logic [1:0] ST_PUSH = 2'd2;

    logic [1:0]         state_q [bits];
    logic [1:0]         state_d [bits];
    logic [IDW-1:0]     ptr_q   [bits];
    logic [IDW-1:0]     ptr_d   [bits];
    logic [IDW-1:0]     w_q     [bits];
    logic [IDW-1:0]     w_d     [bits];
    logic [pckg_sz-1:0] data_q  [bits];
    logic [pckg_sz-1:0] data_d  [bits];

    logic [NDRV-1:0]         pop_q,   pop_d;
    logic [NDRV-1:0]         push_q,  push_d;
    logic [bits*pckg_sz-1:0] dpush_q, dpush_d;
    logic [bits*CW-1:0]      cnt_q,   cnt_d;

    // Per-bus next-state: arbitration, pop/capture, routing and drop counting
    always_comb begin
        logic           found;
        int unsigned    idx;
        int unsigned    win;
        int unsigned    n;
        logic [IDW-1:0] id;

        state_d = state_q;
        ptr_d   = ptr_q;
        w_d     = w_q;
        data_d  = data_q;
        pop_d   = '0;
        push_d  = '0;
        dpush_d = dpush_q;
        cnt_d   = cnt_q;
        found   = 1'b0;
        idx     = 0;
        win     = 0;
        n       = 0;
        id      = '0;

        for (int unsigned b = 0; b < bits; b++) begin
            found = 1'b0;
            idx   = 0;
            win   = 0;
            n     = 0;
            id    = '0;
            case (state_q[b])
                ST_ARB: begin
                    // Round-robin starts at ptr; fixed priority starts at 0
                    for (int unsigned i = 0; i < drvrs; i++) begin
                        idx = i;
                        if (MODE == 0) begin
                            idx = 32'(ptr_q[b]) + i;
                            if (idx >= drvrs) idx = idx - drvrs;
                        end
                        if (!found && pndng[b*drvrs + idx]) begin
                            found = 1'b1;
                            win   = idx;
                        end
                    end
                    if (found) begin
                        w_d[b]     = IDW'(win);
                        ptr_d[b]   = (win + 1 == drvrs) ? '0 : IDW'(win + 1);
                        state_d[b] = ST_POP;
                    end
                end
                ST_POP: begin
                    n          = b*drvrs + 32'(w_q[b]);
                    pop_d[n]   = 1'b1;
                    data_d[b]  = D_pop[n*pckg_sz +: pckg_sz];
                    state_d[b] = ST_PUSH;
                end
                ST_PUSH: begin
                    id = data_q[b][pckg_sz-1 -: IDW];
                    dpush_d[b*pckg_sz +: pckg_sz] = data_q[b];
                    if (id == broadcast) begin
                        for (int unsigned d = 0; d < drvrs; d++) begin
                            push_d[b*drvrs + d] = (d != 32'(w_q[b]));
                        end
                    end else if (32'(id) < drvrs && id != w_q[b]) begin
                        push_d[b*drvrs + 32'(id)] = 1'b1;
                    end else if (cnt_q[b*CW +: CW] != 16'hFFFF) begin
                        cnt_d[b*CW +: CW] = cnt_q[b*CW +: CW] + 16'd1;
                    end
                    state_d[b] = ST_ARB;
                end
                default: state_d[b] = ST_ARB;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned b = 0; b < bits; b++) begin
                state_q[b] <= ST_ARB;
                ptr_q[b]   <= '0;
                w_q[b]     <= '0;
                data_q[b]  <= '0;
            end
            pop_q   <= '0;
            push_q  <= '0;
            dpush_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
            data_q  <= data_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            dpush_q <= dpush_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = dpush_q;
    assign drop_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: round-robin (d0), fixed-priority (d1) and a
// two-bus instance (d2) share clock and reset.
module tb_bus_arbiter_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [3:0]   pndng0, pop0, push0;
    logic [63:0]  dpop0;
    logic [15:0]  dpush0, drop0;
    logic [3:0]   pndng1, pop1, push1;
    logic [63:0]  dpop1;
    logic [15:0]  dpush1, drop1;
    logic [7:0]   pndng2, pop2, push2;
    logic [127:0] dpop2;
    logic [31:0]  dpush2, drop2;

    bus_arbiter_rr #(.bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .MODE(0)) d0 (
        .clk(clk), .reset(reset), .pndng(pndng0), .D_pop(dpop0),
        .pop(pop0), .push(push0), .D_push(dpush0), .drop_cnt(drop0));

    bus_arbiter_rr #(.bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .MODE(1)) d1 (
        .clk(clk), .reset(reset), .pndng(pndng1), .D_pop(dpop1),
        .pop(pop1), .push(push1), .D_push(dpush1), .drop_cnt(drop1));

    bus_arbiter_rr #(.bits(2), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .MODE(0)) d2 (
        .clk(clk), .reset(reset), .pndng(pndng2), .D_pop(dpop2),
        .pop(pop2), .push(push2), .D_push(dpush2), .drop_cnt(drop2));

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  push;
        logic [31:0] dpush;
        logic [31:0] drop;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_drop0 = 16'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference routing for a 4-driver bus with broadcast 8'hFF
    function automatic logic [3:0] route4(input logic [7:0] id, input int unsigned src);
        logic [3:0] m;
        m = '0;
        if (id == 8'hFF) begin
            m = 4'hF;
            m[src] = 1'b0;
        end else if (id < 8'd4 && 32'(id) != src) begin
            m[id[1:0]] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [15:0] rr_pkt(input int unsigned d, input int unsigned tag);
        return {8'((d + 1) % 4), 8'(tag + d)};
    endfunction

    // One packet through d0: queue expectation, wait for pop, check push
    task automatic send0(input int unsigned src, input logic [15:0] pkt);
        exp_t       e;
        logic [3:0] m;
        logic [3:0] g;
        bit         seen;
        m = route4(pkt[15:8], src);
        if (m == 4'h0 && exp_drop0 != 16'hFFFF) exp_drop0 = exp_drop0 + 16'd1;
        e.push  = 8'(m);
        e.dpush = 32'(pkt);
        e.drop  = 32'(exp_drop0);
        sb.push_back(e);
        dpop0[src*16 +: 16] = pkt;
        pndng0[src] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (pop0 != 4'h0) seen = 1'b1;
        end
        g = 4'b0001 << src;
        chk("send_pop", 64'(pop0), 64'(g));
        pndng0[src] = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        chk("send_pop_low", 64'(pop0), 64'h0);
        chk("send_push", 64'(push0), 64'(e.push[3:0]));
        chk("send_dpush", 64'(dpush0), 64'(e.dpush[15:0]));
        chk("send_drop", 64'(drop0), 64'(e.drop[15:0]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  ep, em;
        logic [15:0] ed;
        int unsigned w;
        exp_t        e;
        bit          seen;

        reset  = 1'b0;
        pndng0 = 4'hF;
        pndng1 = 4'hF;
        pndng2 = 8'hFF;
        for (int unsigned d = 0; d < 4; d++) begin
            dpop0[d*16 +: 16]      = rr_pkt(d, 8'hA0);
            dpop1[d*16 +: 16]      = rr_pkt(d, 8'hC0);
            dpop2[d*16 +: 16]      = rr_pkt(d, 8'hB0);
            dpop2[(4+d)*16 +: 16]  = rr_pkt(d, 8'hD0);
        end

        // Reset held two edges with every driver pending
        repeat (2) begin
            @(negedge clk);
            chk("rst_pop0", 64'(pop0), 64'h0);
            chk("rst_push0", 64'(push0), 64'h0);
            chk("rst_dpush0", 64'(dpush0), 64'h0);
            chk("rst_drop0", 64'(drop0), 64'h0);
            chk("rst_pop2", 64'(pop2), 64'h0);
        end
        reset = 1'b1;

        // Fairness: d0 grants 0,1,2,3,0; d1 always 0; d2 both buses like d0
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            ep = 4'h0;
            em = 4'h0;
            ed = 16'h0;
            if (k % 3 == 2) ep = 4'b0001 << (((k - 2) / 3) % 4);
            if (k >= 3 && k % 3 == 0) begin
                w  = 32'(((k - 3) / 3) % 4);
                em = route4(8'((w + 1) % 4), w);
                ed = rr_pkt(w, 8'hA0);
            end
            chk("rr_pop0", 64'(pop0), 64'(ep));
            chk("rr_push0", 64'(push0), 64'(em));
            if (k >= 3 && k % 3 == 0) chk("rr_dpush0", 64'(dpush0), 64'(ed));
            chk("fp_pop1", 64'(pop1), (k % 3 == 2) ? 64'h1 : 64'h0);
            chk("fp_push1", 64'(push1), (k >= 3 && k % 3 == 0) ? 64'h2 : 64'h0);
            chk("mb_pop2", 64'(pop2), 64'({ep, ep}));
            chk("mb_push2", 64'(push2), 64'({em, em}));
            if (k == 14) begin
                pndng0 = 4'h0;
                pndng1 = 4'h0;
                pndng2 = 8'h0;
            end
        end
        chk("rr_drop0", 64'(drop0), 64'h0);
        repeat (2) @(negedge clk);
        chk("idle_pop0", 64'(pop0), 64'h0);
        chk("idle_push0", 64'(push0), 64'h0);

        // Directed routing on d0
        send0(1, 16'h02AB);
        send0(2, 16'hFF55);
        send0(0, 16'h0711);
        send0(3, 16'h0333);

        // Counter saturation
        @(negedge clk);
        force d0.cnt_q = 16'hFFFF;
        @(negedge clk);
        release d0.cnt_q;
        exp_drop0 = 16'hFFFF;
        @(negedge clk);
        chk("sat_preload", 64'(drop0), 64'hFFFF);
        send0(1, 16'h0912);
        send0(0, 16'h0399);

        // Simultaneous traffic on both buses of d2
        dpop2[(0*4+1)*16 +: 16] = 16'h0312;
        dpop2[(1*4+2)*16 +: 16] = 16'hFF34;
        e.push  = {route4(8'hFF, 2), route4(8'h03, 1)};
        e.dpush = {16'hFF34, 16'h0312};
        e.drop  = 32'h0;
        sb.push_back(e);
        pndng2 = 8'b0100_0010;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (pop2 != 8'h0) seen = 1'b1;
        end
        chk("mb2_pop", 64'(pop2), 64'h42);
        pndng2 = 8'h0;
        @(negedge clk);
        e = sb.pop_front();
        chk("mb2_push", 64'(push2), 64'(e.push));
        chk("mb2_dpush", 64'(dpush2), 64'(e.dpush));
        chk("mb2_drop", 64'(drop2), 64'(e.drop));

        // Reset during PUSH of an unroutable packet: lost, not counted
        dpop2[0 +: 16] = 16'h0700;
        pndng2 = 8'h01;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (pop2 != 8'h0) seen = 1'b1;
        end
        chk("mr_pop", 64'(pop2), 64'h1);
        pndng2 = 8'h0;
        reset  = 1'b0;
        @(negedge clk);
        chk("mr_push", 64'(push2), 64'h0);
        chk("mr_dpush", 64'(dpush2), 64'h0);
        chk("mr_drop", 64'(drop2), 64'h0);
        chk("mr_drop0", 64'(drop0), 64'h0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("mr_after_push", 64'(push2), 64'h0);
        chk("mr_after_drop", 64'(drop2), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised multi-bus packet arbiter and router, the next-generation replacement for `bs_gnrtr_n_rbtr` in the bus subsystem.
- Sits between the per-driver FIFOs (drivers/monitors) and `bits` independent shared buses.
- On each bus it selects one pending driver, pops its head packet and routes it by destination ID to one driver or to all drivers (broadcast).
- New versus the previous generation: selectable round-robin or fixed-priority arbitration, source exclusion on broadcast, and per-bus counting of dropped (unroutable) packets.

## Interface
Parameters:
- `bits`, 1: number of independent buses.
- `drvrs`, 4: drivers per bus, 2..255.
- `pckg_sz`, 16: packet width, ≥ 9.
- `broadcast`, 8'hFF: destination ID meaning "all drivers".
- `MODE`, 0: arbitration mode; 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports (flat index for bus b, driver d is n = b*drvrs+d):
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `pndng`  in  bits*drvrs  driver FIFO n non-empty.
- `D_pop`  in  bits*drvrs*pckg_sz  head packet of FIFO n at slice [n*pckg_sz +: pckg_sz].
- `pop`  out  bits*drvrs  one-cycle pop strobe to FIFO n.
- `push`  out  bits*drvrs  one-cycle write strobe to receiver n.
- `D_push`  out  bits*pckg_sz  packet on bus b; shared by all receivers of b.
- `drop_cnt`  out  bits*16  per-bus count of dropped packets, saturating at 16'hFFFF.

## Operation
- Buses are fully independent: one FSM, pointer, data register and counter per bus.
- Packet format: destination ID = D_pop[pckg_sz-1 -: 8]. Payload is not interpreted.
- Per-bus FSM:
  - ARB: if no `pndng` bit of the bus is set, stay in ARB. Otherwise pick winner w, register w, go to POP.
  - POP: assert `pop[w]` for this cycle only. Capture D_pop slice w into the data register and decode the destination. Go to PUSH.
  - PUSH: drive `D_push[b]` from the data register. Assert `push` per the routing rule below for this cycle only. Go to ARB.
- Winner selection:
  - MODE 0: search starts at `ptr`, wrapping modulo drvrs. After each grant, ptr = (w+1) mod drvrs.
  - MODE 1: lowest-index pending driver wins; ptr is unused.
- Routing, evaluated on the captured ID:
  - ID == `broadcast`: push to every driver of the bus except source w.
  - ID < drvrs and ID != w: push to driver ID only.
  - Any other ID (out of range or self-addressed): no push, and drop_cnt[b] increments by 1, saturating. A dropped packet still consumes its PUSH cycle.
- `D_push[b]` holds the last routed or dropped packet until the next PUSH.
- Outputs `pop`/`push` come directly from registers, with no combinational path from inputs.
- If `pndng[w]` is deasserted during POP, the pop is still issued. Keeping `pndng` stable until popped is the FIFO's responsibility.
- Reset (reset==0 at a clock edge), for all buses:
  - state = ARB, ptr = 0.
  - `pop`, `push`, `D_push` and `drop_cnt` = 0.
  - A packet already popped but not yet pushed is lost and not counted.

## Timing
- Edge 0: ARB sees `pndng`.
- Edge 1 (POP): `pop` high; D_pop sampled.
- Edge 2 (PUSH): `push` and `D_push` valid.
- Latency from `pndng` to `push`: 2 cycles.
- Throughput: one packet per 3 cycles per bus. Back-to-back packets give ARB→POP→PUSH→ARB with no idle cycle.
- `pop` and `push` are never high for more than one consecutive cycle per bus, and never in the same cycle on the same bus.
- `drop_cnt` updates on the PUSH edge.
- Reset must be held low for ≥ 1 clock edge. Normal operation resumes on the first edge with reset high.

## Test plan
- Reset: hold reset low 2 cycles with all `pndng`=1 → all outputs 0 and no pop. The first `pop` appears 2 edges after release, on driver 0.
- Unicast: bits=1, drvrs=4, driver 1 pending with packet 16'h02AB → pop[1] pulses, next cycle push=4'b0100 and D_push=16'h02AB, drop_cnt=0.
- Broadcast: driver 2 sends 16'hFF55 → push=4'b1011 in a single cycle, D_push=16'hFF55.
- Round-robin fairness: MODE 0, all four `pndng` held high → grants occur in order 0,1,2,3,0, each 3 cycles apart. Repeated with MODE 1 → every grant goes to 0.
- Drops: packets with IDs 8'h07 (out of range) and self-addressed (driver 3 → ID 3) → no push, drop_cnt=2. Preloading the counter path to 16'hFFFF and dropping again → counter stays at 16'hFFFF.
- Multi-bus and mid-operation reset: bits=2, simultaneous traffic on both buses → independent, correctly-timed grants. Asserting reset during PUSH → push and D_push are 0 on the next edge and the lost packet is not counted.
